usb_rx_bit_timer: RTL and testbench

//   Parametrised bit-timing unit for the USB receiver.

---
 rtl/usb_rx_pkg.sv | 17 +
 rtl/flex_counter.sv | 38 +++
 rtl/usb_rx_bit_timer.sv | 100 ++++++++++
 tb/tb_usb_rx_bit_timer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared constants for the USB receive path: default bit timing and derived counter widths.
package usb_rx_pkg;

  localparam int USB_OVERSAMPLE    = 8;
  localparam int USB_SAMPLE_PT     = 3;
  localparam int USB_BITS_PER_BYTE = 8;
  localparam int USB_MAX_RUN       = 7;

  localparam int PHASE_W = $clog2(USB_OVERSAMPLE);
  localparam int BIT_W   = $clog2(USB_BITS_PER_BYTE);

  // Width needed to hold a run count that saturates at max_run.
  function automatic int run_width(input int max_run);
    return (max_run < 1) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic wrapping counter: counts 0..rollover_val-1 on count_enable, registered pulse on wrap.
module flex_counter #(
  parameter int NUM_BITS = 3
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS:0]   rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag
);

  logic at_last;

  assign at_last = ({1'b0, count_out} == (rollover_val - (NUM_BITS+1)'(1)));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else if (clear) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else if (count_enable) begin
      if (at_last) begin
        count_out     <= '0;
        rollover_flag <= 1'b1;
      end else begin
        count_out     <= count_out + NUM_BITS'(1);
        rollover_flag <= 1'b0;
      end
    end else begin
      rollover_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/usb_rx_bit_timer.sv
// USB RX bit timer: edge-resynchronised phase counter, sample strobe, byte counting and
// detection of over-long runs without transitions.
module usb_rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int OVERSAMPLE    = USB_OVERSAMPLE,
  parameter int SAMPLE_PT     = USB_SAMPLE_PT,
  parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE,
  parameter int MAX_RUN       = USB_MAX_RUN,
  parameter int RESYNC_EN     = 1
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             d_edge,
  input  logic                             rcving,
  input  logic                             stuff_skip,
  output logic                             shift_enable,
  output logic                             byte_received,
  output logic [$clog2(BITS_PER_BYTE)-1:0] bit_cnt,
  output logic                             run_err
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(BITS_PER_BYTE);
  localparam int RW = run_width(MAX_RUN);

  if (SAMPLE_PT >= OVERSAMPLE) begin : g_bad_sample_pt
    $error("usb_rx_bit_timer: SAMPLE_PT must be below OVERSAMPLE");
  end
  if (OVERSAMPLE < 4) begin : g_bad_oversample
    $error("usb_rx_bit_timer: OVERSAMPLE must be at least 4");
  end
  if (BITS_PER_BYTE < 2) begin : g_bad_bits_per_byte
    $error("usb_rx_bit_timer: BITS_PER_BYTE must be at least 2");
  end
  if (MAX_RUN < 1) begin : g_bad_max_run
    $error("usb_rx_bit_timer: MAX_RUN must be at least 1");
  end

  logic [PW-1:0] phase_q;
  logic [RW-1:0] run_q;
  logic          sample_cycle;
  logic          wrap;
  logic          resync;

  assign sample_cycle = rcving && (phase_q == PW'(SAMPLE_PT));
  assign wrap         = (phase_q == PW'(OVERSAMPLE - 1));
  assign resync       = d_edge && (RESYNC_EN != 0);

  // Gated by n_rst so the strobe stays low during reset even when SAMPLE_PT is 0.
  assign shift_enable = n_rst && sample_cycle && !stuff_skip;

  // The edge cycle counts as phase 0, so the cycle after an edge is phase 1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q <= '0;
    end else if (!rcving) begin
      phase_q <= '0;
    end else if (resync) begin
      phase_q <= PW'(1);
    end else if (wrap) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + PW'(1);
    end
  end

  // Run count saturates at MAX_RUN; run_err is sticky for the rest of the packet.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      run_q   <= '0;
      run_err <= 1'b0;
    end else if (!rcving) begin
      run_q   <= '0;
      run_err <= 1'b0;
    end else if (d_edge) begin
      run_q   <= '0;
    end else if (wrap) begin
      if (run_q != RW'(MAX_RUN)) begin
        run_q <= run_q + RW'(1);
      end
      if (run_q == RW'(MAX_RUN - 1)) begin
        run_err <= 1'b1;
      end
    end
  end

  flex_counter #(
    .NUM_BITS(BW)
  ) u_bit_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!rcving),
    .count_enable (shift_enable),
    .rollover_val ((BW+1)'(BITS_PER_BYTE)),
    .count_out    (bit_cnt),
    .rollover_flag(byte_received)
  );

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// Randomised bench for usb_rx_bit_timer: a timeline-based reference model predicts every
// cycle's outputs into a queue that an independent monitor drains and compares.
module tb_usb_rx_bit_timer;
  import usb_rx_pkg::*;

  localparam int OS  = USB_OVERSAMPLE;
  localparam int SP  = USB_SAMPLE_PT;
  localparam int BPB = USB_BITS_PER_BYTE;
  localparam int MR  = USB_MAX_RUN;
  localparam int W   = BIT_W + 3;

  logic             clk;
  logic             n_rst;
  logic             d_edge;
  logic             rcving;
  logic             stuff_skip;
  logic             shift_enable;
  logic             byte_received;
  logic [BIT_W-1:0] bit_cnt;
  logic             run_err;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: cycle index, the cycle treated as phase 0 / run origin, and byte state.
  int   cyc     = 0;
  int   m_align = 0;
  int   m_bits  = 0;
  logic m_err   = 1'b0;
  logic m_byte  = 1'b0;

  usb_rx_bit_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_edge       (d_edge),
    .rcving       (rcving),
    .stuff_skip   (stuff_skip),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .bit_cnt      (bit_cnt),
    .run_err      (run_err)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_rst      = 1'b0;
    d_edge     = 1'b0;
    rcving     = 1'b0;
    stuff_skip = 1'b0;
  end

  task automatic model_idle();
    m_align = cyc + 1;
    m_bits  = 0;
    m_err   = 1'b0;
    m_byte  = 1'b0;
  endtask

  // Drive one cycle of inputs and push the outputs the model predicts for that cycle.
  task automatic drive_cycle(input logic rst_v, input logic rcv_v, input logic edge_v,
                             input logic skip_v);
    int   phase;
    logic se;
    @(posedge clk);
    #1;
    n_rst      = rst_v;
    rcving     = rcv_v;
    d_edge     = edge_v;
    stuff_skip = skip_v;
    if (!rst_v) begin
      exp_q.push_back('0);
      model_idle();
    end else begin
      phase = (cyc - m_align) % OS;
      se    = rcv_v && (phase == SP) && !skip_v;
      exp_q.push_back({se, m_byte, BIT_W'(m_bits), m_err});
      if (!rcv_v) begin
        model_idle();
      end else begin
        m_byte = 1'b0;
        if (se) begin
          m_bits = m_bits + 1;
          if (m_bits == BPB) begin
            m_bits = 0;
            m_byte = 1'b1;
          end
        end
        if (edge_v) m_align = cyc;
        if ((cyc + 1 - m_align) >= OS * MR) m_err = 1'b1;
      end
    end
    cyc = cyc + 1;
  endtask

  // mode 0: aligned edges, 1: slow transmitter, 2: single edge then silence, 3: sparse random
  task automatic run_session(input int mode, input int len, input bit skip_en);
    logic e;
    logic s;
    for (int i = 0; i < len; i++) begin
      case (mode)
        0:       e = (i % OS == 0);
        1:       e = (i % (OS + 1) == 0);
        2:       e = (i == 0);
        default: e = ($urandom_range(0, 9) == 0);
      endcase
      s = skip_en && ($urandom_range(0, 15) == 0);
      drive_cycle(1'b1, 1'b1, e, s);
    end
  endtask

  task automatic idle_gap(input int len);
    for (int i = 0; i < len; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {shift_enable, byte_received, bit_cnt, run_err};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL outputs t=%0t actual se=%0b br=%0b bit_cnt=%0d run_err=%0b required se=%0b br=%0b bit_cnt=%0d run_err=%0b",
                 $time, act_v[W-1], act_v[W-2], act_v[BIT_W:1], act_v[0],
                 exp_v[W-1], exp_v[W-2], exp_v[BIT_W:1], exp_v[0]);
      end
    end
  end

  initial begin
    logic [W-1:0] rst_act;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle_gap(2);

    // Directed: aligned stream over one full byte, then a long silent run.
    run_session(0, 64, 1'b0);
    idle_gap(3);
    run_session(2, 75, 1'b0);
    idle_gap(2);
    // Abort mid-byte, then restart.
    run_session(0, 44, 1'b0);
    idle_gap(6);
    run_session(0, 20, 1'b1);
    idle_gap(2);

    for (int k = 0; k < 25; k++) begin
      int mode;
      mode = $urandom_range(0, 3);
      run_session(mode, (mode == 2) ? $urandom_range(50, 90) : $urandom_range(20, 140), 1'b1);
      idle_gap($urandom_range(1, 5));
    end

    // Asynchronous reset mid-packet: outputs must drop before the next clock edge.
    run_session(0, 30, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    rst_act = {shift_enable, byte_received, bit_cnt, run_err};
    checks++;
    if (rst_act !== '0) begin
      failures++;
      $display("FAIL async_reset actual=%b required=%b", rst_act, {W{1'b0}});
    end
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_session(3, 40, 1'b1);
    idle_gap(2);

    for (int k = 0; k < 5; k++) begin
      run_session($urandom_range(0, 3), $urandom_range(30, 120), 1'b1);
      idle_gap($urandom_range(1, 4));
    end

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
